pipeline_stall_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges load-use

---
 rtl/pipeline_stall_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Central stall/flush sequencer for a 5-stage MIPS pipeline. It merges load-use hazards,
//   I-cache and D-cache miss stalls and taken-branch redirects into one prioritized set of
//   stage write-enables plus bubble/flush controls. It also keeps saturating per-cause stall
//   counters and a sticky stall watchdog for debug and performance measurement.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   idex_memread   in   1      instruction in EX is a load
//   idex_rt        in   REG_W  load destination register
//   ifid_rs        in   REG_W  rs of instruction in ID
//   ifid_rt        in   REG_W  rt of instruction in ID
//   ifid_use_rt    in   1      ID instruction reads rt
//   branch_taken   in   1      ID resolved a taken branch/jump this cycle
//   icache_stall   in   1      fetch not ready
//   dcache_stall   in   1      data memory access not ready
//   pc_write       out  1      PC load enable
//   ifid_write     out  1      IF/ID load enable
//   ifid_flush     out  1      IF/ID loads NOP
//   idex_bubble    out  1      ID/EX loads NOP
//   exmem_write    out  1      EX/MEM load enable
//   memwb_write    out  1      MEM/WB load enable
//   cause          out  2      previous-cycle cause: 0 RUN, 1 LU, 2 ISTALL, 3 DSTALL
//   lu_cnt         out  CNT_W  load-use bubbles inserted
//   istall_cnt     out  CNT_W  I-cache stall cycles
//   dstall_cnt     out  CNT_W  D-cache stall cycles
//   flush_cnt      out  CNT_W  branch flushes issued
//   stall_timeout  out  1      sticky watchdog flag
// ---------------------------------------------------------------------------------------------
module pipeline_stall_ctrl #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_use_rt,
   input  logic             branch_taken,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic [1:0]       cause,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] istall_cnt,
   output logic [CNT_W-1:0] dstall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             stall_timeout
);

   localparam int unsigned       WdW    = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0]    WdMax  = WdW'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CntMax = '1;

   typedef enum logic [2:0] {CondRun, CondLu, CondIStall, CondDStall, CondFlush} cond_e;

   cond_e            cond;
   logic             lu_hazard;
   logic [1:0]       cause_d, cause_q;
   logic [CNT_W-1:0] lu_cnt_d, lu_cnt_q;
   logic [CNT_W-1:0] istall_cnt_d, istall_cnt_q;
   logic [CNT_W-1:0] dstall_cnt_d, dstall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   logic [WdW-1:0]   wd_cnt_d, wd_cnt_q;
   logic             timeout_d, timeout_q;

   // Register 0 is never a real dependency, so a load into $zero never stalls.
   always_comb begin
      lu_hazard = idex_memread && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
   end

   // Strict priority: a D-stall freezes everything, so lower-priority causes simply re-present
   // themselves once the stall clears.
   always_comb begin
      cond = CondRun;
      if (dcache_stall) begin
         cond = CondDStall;
      end else if (icache_stall) begin
         cond = CondIStall;
      end else if (lu_hazard) begin
         cond = CondLu;
      end else if (branch_taken) begin
         cond = CondFlush;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      cause_d     = 2'd0;
      unique case (cond)
         CondDStall: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            cause_d     = 2'd3;
         end
         CondIStall: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cause_d     = 2'd2;
         end
         CondLu: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cause_d     = 2'd1;
         end
         CondFlush: begin
            ifid_flush = 1'b1;
         end
         CondRun: begin
         end
         default: begin
         end
      endcase
   end

   // Saturating statistics counters.
   always_comb begin
      lu_cnt_d     = lu_cnt_q;
      istall_cnt_d = istall_cnt_q;
      dstall_cnt_d = dstall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if ((cond == CondLu) && (lu_cnt_q != CntMax)) begin
         lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
      if ((cond == CondIStall) && (istall_cnt_q != CntMax)) begin
         istall_cnt_d = istall_cnt_q + CNT_W'(1);
      end
      if ((cond == CondDStall) && (dstall_cnt_q != CntMax)) begin
         dstall_cnt_d = dstall_cnt_q + CNT_W'(1);
      end
      if ((cond == CondFlush) && (flush_cnt_q != CntMax)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Watchdog counts consecutive cycles without PC progress; the flag is sticky until reset.
   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      if (pc_write) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WdMax) begin
         wd_cnt_d = wd_cnt_q + WdW'(1);
      end
      if (wd_cnt_d == WdMax) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_q      <= 2'd0;
         lu_cnt_q     <= '0;
         istall_cnt_q <= '0;
         dstall_cnt_q <= '0;
         flush_cnt_q  <= '0;
         wd_cnt_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         cause_q      <= cause_d;
         lu_cnt_q     <= lu_cnt_d;
         istall_cnt_q <= istall_cnt_d;
         dstall_cnt_q <= dstall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         wd_cnt_q     <= wd_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign cause         = cause_q;
   assign lu_cnt        = lu_cnt_q;
   assign istall_cnt    = istall_cnt_q;
   assign dstall_cnt    = dstall_cnt_q;
   assign flush_cnt     = flush_cnt_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       idex_memread = 1'b0;
   logic [4:0] idex_rt = '0;
   logic [4:0] ifid_rs = '0;
   logic [4:0] ifid_rt = '0;
   logic       ifid_use_rt = 1'b0;
   logic       branch_taken = 1'b0;
   logic       icache_stall = 1'b0;
   logic       dcache_stall = 1'b0;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write;
   logic [1:0]  cause;
   logic [15:0] lu_cnt, istall_cnt, dstall_cnt, flush_cnt;
   logic        stall_timeout;

   logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s;
   logic        exmem_write_s, memwb_write_s;
   logic [1:0]  cause_s;
   logic [2:0]  lu_cnt_s, istall_cnt_s, dstall_cnt_s, flush_cnt_s;
   logic        stall_timeout_s;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.REG_W(5), .CNT_W(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
      .branch_taken(branch_taken), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_write(exmem_write), .memwb_write(memwb_write),
      .cause(cause), .lu_cnt(lu_cnt), .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt),
      .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
   );

   // Narrow-counter instance so saturation is reachable in a few cycles.
   pipeline_stall_ctrl #(.REG_W(5), .CNT_W(3), .TIMEOUT(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
      .branch_taken(branch_taken), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .pc_write(pc_write_s), .ifid_write(ifid_write_s), .ifid_flush(ifid_flush_s),
      .idex_bubble(idex_bubble_s), .exmem_write(exmem_write_s), .memwb_write(memwb_write_s),
      .cause(cause_s), .lu_cnt(lu_cnt_s), .istall_cnt(istall_cnt_s),
      .dstall_cnt(dstall_cnt_s), .flush_cnt(flush_cnt_s), .stall_timeout(stall_timeout_s)
   );

   // ctl order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write}
   // kind: 0 run, 1 lu, 2 istall, 3 dstall, 4 flush
   typedef struct {
      logic       mr;
      logic [4:0] ex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rt;
      logic       br;
      logic       ic;
      logic       dc;
      logic [5:0] exp_ctl;
      logic [1:0] exp_cause;
      int         kind;
   } vec_t;

   vec_t vecs[12];
   int   mcnt[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic use_rt, input logic br,
                        input logic ic, input logic dc);
      idex_memread = mr;
      idex_rt      = ex_rt;
      ifid_rs      = rs;
      ifid_rt      = rt;
      ifid_use_rt  = use_rt;
      branch_taken = br;
      icache_stall = ic;
      dcache_stall = dc;
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [5:0] ctl();
      return {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write};
   endfunction

   initial begin
      vecs[0]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd1, 1};
      vecs[1]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 0};
      vecs[2]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 0};
      vecs[3]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd1, 1};
      vecs[4]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 0};
      vecs[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111011, 2'd0, 4};
      vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, 2'd3, 3};
      vecs[7]  = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000111, 2'd2, 2};
      vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000111, 2'd2, 2};
      vecs[9]  = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000111, 2'd1, 1};
      vecs[10] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 2'd3, 3};
      vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 0};
      for (int k = 0; k < 5; k++) mcnt[k] = 0;

      // Reset state
      do_reset();
      check("rst_cause", 32'(cause), 32'd0);
      check("rst_lu_cnt", 32'(lu_cnt), 32'd0);
      check("rst_dstall_cnt", 32'(dstall_cnt), 32'd0);
      check("rst_timeout", 32'(stall_timeout), 32'd0);

      // Table-driven single-cycle behaviour with a running counter model
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].use_rt,
               vecs[i].br, vecs[i].ic, vecs[i].dc);
         @(negedge clk);
         check($sformatf("v%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
         check($sformatf("v%0d_excl", i), 32'(ifid_flush & idex_bubble), 32'd0);
         step();
         if (vecs[i].kind != 0) mcnt[vecs[i].kind]++;
         check($sformatf("v%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
         check($sformatf("v%0d_lu_cnt", i), 32'(lu_cnt), 32'(mcnt[1]));
         check($sformatf("v%0d_istall_cnt", i), 32'(istall_cnt), 32'(mcnt[2]));
         check($sformatf("v%0d_dstall_cnt", i), 32'(dstall_cnt), 32'(mcnt[3]));
         check($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(mcnt[4]));
      end
      check("tbl_timeout", 32'(stall_timeout), 32'd0);

      // I-stall masks a simultaneous load-use hazard for 3 cycles
      do_reset();
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("is_lu_bubble%0d", i), 32'(idex_bubble), 32'd1);
         step();
      end
      check("is_lu_istall_cnt", 32'(istall_cnt), 32'd3);
      check("is_lu_lu_cnt", 32'(lu_cnt), 32'd0);
      check("is_lu_cause", 32'(cause), 32'd2);

      // Watchdog: 7 stall, 1 run, 7 stall never reaches TIMEOUT=8
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (7) step();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (7) step();
      check("wd_7_1_7_timeout", 32'(stall_timeout), 32'd0);
      check("wd_7_1_7_dstall", 32'(dstall_cnt), 32'd14);

      // Watchdog: 8 consecutive stalls set the sticky flag on the 8th edge
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (7) step();
      check("wd_edge7_timeout", 32'(stall_timeout), 32'd0);
      step();
      check("wd_edge8_timeout", 32'(stall_timeout), 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step();
      check("wd_sticky_timeout", 32'(stall_timeout), 32'd1);

      // Asynchronous reset in the middle of a D-stall
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step();
      check("pre_rst_dstall", 32'(dstall_cnt), 32'd11);
      check("pre_rst_cause", 32'(cause), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_cause", 32'(cause), 32'd0);
      check("async_rst_dstall", 32'(dstall_cnt), 32'd0);
      check("async_rst_timeout", 32'(stall_timeout), 32'd0);
      check("in_rst_ctl", 32'(ctl()), 32'd0);
      step();
      rst_n = 1'b1;

      // Saturation on the 3-bit instance: 10 load-use cycles stop at 7
      drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (7) step();
      check("sat_lu_at7", 32'(lu_cnt_s), 32'd7);
      repeat (3) step();
      check("sat_lu_hold", 32'(lu_cnt_s), 32'd7);
      check("wide_lu_cnt", 32'(lu_cnt), 32'd10);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
